// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Contents:
//   arb_state_t  - arbiter FSM state (idle / transaction in flight)
//   arb_owner_t  - requester index, ARB_M0 = CPU data port, ARB_M1 = loader/DMA
//   otherOwner() - the requester that is not the given one
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef logic arb_owner_t;

  localparam arb_owner_t ARB_M0 = 1'b0;
  localparam arb_owner_t ARB_M1 = 1'b1;

  function automatic arb_owner_t otherOwner(input arb_owner_t owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker.
// Ports:
//   i_req       [1:0] request vector, bit N = requester N
//   i_last            requester that completed most recently
//   o_gnt_valid       at least one request is pending
//   o_gnt_idx         chosen requester (only meaningful when o_gnt_valid)
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_t i_last,
  output logic       o_gnt_valid,
  output arb_owner_t o_gnt_idx
);

  // A lone request always wins; on a tie the requester that was not served
  // last goes first, which bounds the wait of either side to one transaction.
  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_idx   = ARB_M0;
    case (i_req)
      2'b01:   o_gnt_idx = ARB_M0;
      2'b10:   o_gnt_idx = ARB_M1;
      2'b11:   o_gnt_idx = otherOwner(i_last);
      default: o_gnt_idx = ARB_M0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between the CPU data port (m0) and the
// instruction loader / DMA (m1). Round-robin grant, one transaction in
// flight, all downstream signals registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction whose
// memory never answers within TIMEOUT_CYC busy cycles (ready + err pulse,
// read data forced to all ones). Without it the arbiter waits forever and
// o_err is tied low.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mN_req/we/addr/wdata       requester N transaction, held until ready
//   o_mN_rdata, o_mN_ready       requester N read data and completion pulse
//   o_mem_req/we/addr/wdata      downstream request, held until i_mem_ready
//   i_mem_rdata, i_mem_ready     downstream read data and completion pulse
//   o_busy                       transaction in flight
//   o_owner                      current / most recently granted requester
//   o_err                        timeout pulse, coincident with owner's ready
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_ready,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_ready,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output arb_owner_t        o_owner,
  output logic              o_err
);

  arb_state_t  r_state;
  arb_state_t  w_nextState;
  arb_owner_t  r_last;
  arb_owner_t  r_owner;
  logic        r_memReq;
  logic        r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic        r_m0Ready;
  logic        r_m1Ready;
  logic [DATA_W-1:0] r_m0Rdata;
  logic [DATA_W-1:0] r_m1Rdata;
  logic        r_busy;
  logic        r_err;

  logic        w_gntValid;
  arb_owner_t  w_gntIdx;
  logic        w_grant;
  logic        w_finish;
  logic        w_timeout;
  logic [DATA_W-1:0] w_finRdata;

  // An illegal timeout would make the counter compare meaningless.
  if (TIMEOUT_CYC < 2) begin : g_badTimeout
    $error("mem_port_arbiter: TIMEOUT_CYC must be >= 2");
  end

  mem_arb_rr u_rr (
    .i_req       ({i_m1_req, i_m0_req}),
    .i_last      (r_last),
    .o_gnt_valid (w_gntValid),
    .o_gnt_idx   (w_gntIdx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_busyCnt;

  // Counts completed busy cycles; value k means k cycles have passed without
  // mem_ready, so the last allowed cycle is TIMEOUT_CYC-1. It never needs to
  // saturate because reaching that value always leaves BUSY.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busyCnt <= '0;
    end else if (w_grant) begin
      r_busyCnt <= '0;
    end else if (r_state == ARB_BUSY) begin
      r_busyCnt <= r_busyCnt + 1'b1;
    end
  end

  // A real completion in the expiry cycle takes precedence over the timeout.
  assign w_timeout = (r_state == ARB_BUSY) && !i_mem_ready &&
                     (r_busyCnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finRdata = w_timeout ? {DATA_W{1'b1}} : i_mem_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ARB_IDLE;
    else       r_state <= w_nextState;
  end

  // IDLE grants whenever anyone asks; mem_ready seen in IDLE is ignored
  // because w_finish is only raised from BUSY.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gntValid) begin
          w_grant     = 1'b1;
          w_nextState = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (i_mem_ready || w_timeout) begin
          w_finish    = 1'b1;
          w_nextState = ARB_IDLE;
        end
      end
      default: w_nextState = ARB_IDLE;
    endcase
  end

  // Downstream fields are captured once at grant and then left alone, so the
  // memory sees a stable request even if the requester changes its inputs.
  // Ready/err default low every cycle, making them single-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last     <= ARB_M1;
      r_owner    <= ARB_M1;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_m0Ready  <= 1'b0;
      r_m1Ready  <= 1'b0;
      r_m0Rdata  <= '0;
      r_m1Rdata  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_m0Ready <= 1'b0;
      r_m1Ready <= 1'b0;
      r_err     <= 1'b0;
      if (w_grant) begin
        r_memReq <= 1'b1;
        r_busy   <= 1'b1;
        r_owner  <= w_gntIdx;
        if (w_gntIdx == ARB_M1) begin
          r_memWe    <= i_m1_we;
          r_memAddr  <= i_m1_addr;
          r_memWdata <= i_m1_wdata;
        end else begin
          r_memWe    <= i_m0_we;
          r_memAddr  <= i_m0_addr;
          r_memWdata <= i_m0_wdata;
        end
      end
      if (w_finish) begin
        r_memReq <= 1'b0;
        r_busy   <= 1'b0;
        r_last   <= r_owner;
        r_err    <= w_timeout;
        if (r_owner == ARB_M1) begin
          r_m1Ready <= 1'b1;
          r_m1Rdata <= w_finRdata;
        end else begin
          r_m0Ready <= 1'b1;
          r_m0Rdata <= w_finRdata;
        end
      end
    end
  end

  assign o_mem_req   = r_memReq;
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;
  assign o_m0_ready  = r_m0Ready;
  assign o_m1_ready  = r_m1Ready;
  assign o_m0_rdata  = r_m0Rdata;
  assign o_m1_rdata  = r_m1Rdata;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;
  assign o_err       = r_err;

endmodule
